rr_encoder_arbiter: RTL

//  Round-robin arbiter sharing one downstream resource among IN requesters.
//  - Issues a one-hot grant, plus the binary index of the granted requester.
//  - The index is the same code a one-hot-to-binary encoder produces for gnt.
//  - Holds the grant until the owner signals done or drops its request.
//  - Sits in front of shared datapaths that are steered by the encoded index.

---
 rtl/rr_encoder_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/rr_encoder_arbiter.sv
// rtl/rr_encoder_arbiter.sv - round-robin arbiter with one-hot grant and encoded grant index
module rr_encoder_arbiter #(
    parameter int IN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN-1:0]         req,
    input  logic                  done,
    output logic [IN-1:0]         gnt,
    output logic [$clog2(IN)-1:0] gnt_idx,
    output logic                  gnt_valid
);
    localparam int W = $clog2(IN);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_d;
    logic [W-1:0]    ptr, ptr_d;
    logic [IN-1:0]   gnt_d;
    logic [W-1:0]    idx_d;
    logic [W-1:0]    win;
    logic [W-1:0]    cand;
    logic            found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        win     = '0;
        cand    = '0;
        found   = 1'b0;

        // Search upward from ptr; the W-bit sum wraps IN-1 back to 0 because IN is a power of two.
        for (int i = 0; i < IN; i++) begin
            cand = ptr + W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    idx_d      = win;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (done || !req[gnt_idx]) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    ptr_d   = gnt_idx + W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_valid = |gnt;
endmodule
